// File: rtl/etaii_correct_ctrl.sv
// Variable-latency controller for a segmented error-tolerant adder: one exactness check per op,
// then optional iterative carry settling. Optional counters under `ETAII_CTRL_STATS_EN.
module etaii_correct_ctrl #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEG   = 4,
   parameter int unsigned ITW   = $clog2(WIDTH / SEG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_exact,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef ETAII_CTRL_STATS_EN
   input  logic             stat_clr,
   output logic [31:0]      stat_ops,
   output logic [31:0]      stat_errs,
   output logic [31:0]      stat_iters,
`endif
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_err,
   output logic [ITW-1:0]   out_iters
);

   localparam int unsigned NSEG = WIDTH / SEG;
   // cin_1 is exact after the initial load, so at most NSEG-2 updates are ever needed
   localparam logic [ITW-1:0] MaxIters = ITW'(NSEG - 2);

   typedef enum logic [1:0] {StIdle, StChk, StCorr, StDone} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             exact_q, exact_d, err_q, err_d;
   logic [NSEG-1:0]  cin_q, cin_d;
   logic [ITW-1:0]   iters_q, iters_d;

   logic [NSEG-1:0]  seg_co, seg_gen, nxt, init_cin;
   logic [WIDTH-1:0] seg_sum;
   logic [SEG:0]     seg_t, gen_t;

   // Segment adders on registered operands plus generate-only carries of the incoming operands
   always_comb begin
      seg_co  = '0;
      seg_gen = '0;
      seg_sum = '0;
      seg_t   = '0;
      gen_t   = '0;
      for (int k = 0; k < NSEG; k++) begin
         seg_t = {1'b0, a_q[k*SEG +: SEG]} + {1'b0, b_q[k*SEG +: SEG]} + {{SEG{1'b0}}, cin_q[k]};
         seg_sum[k*SEG +: SEG] = seg_t[SEG-1:0];
         seg_co[k] = seg_t[SEG];
         gen_t = {1'b0, in_a[k*SEG +: SEG]} + {1'b0, in_b[k*SEG +: SEG]};
         seg_gen[k] = gen_t[SEG];
      end
      nxt      = {seg_co[NSEG-2:0], 1'b0};
      init_cin = {seg_gen[NSEG-2:0], 1'b0};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         exact_q <= 1'b0;
         err_q   <= 1'b0;
         cin_q   <= '0;
         iters_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         exact_q <= exact_d;
         err_q   <= err_d;
         cin_q   <= cin_d;
         iters_q <= iters_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      exact_d = exact_q;
      err_d   = err_q;
      cin_d   = cin_q;
      iters_d = iters_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               exact_d = in_exact;
               cin_d   = init_cin;
               iters_d = '0;
               err_d   = 1'b0;
               state_d = StChk;
            end
         end
         StChk: begin
            if (nxt == cin_q) begin
               state_d = StDone;
            end else begin
               err_d = 1'b1;
               if (exact_q) begin
                  cin_d   = nxt;
                  iters_d = ITW'(1);
                  state_d = StCorr;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StCorr: begin
            if (nxt == cin_q || iters_q == MaxIters) begin
               state_d = StDone;
            end else begin
               cin_d   = nxt;
               iters_d = iters_q + ITW'(1);
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      out_sum   = out_valid ? seg_sum : '0;
      out_cout  = out_valid & seg_co[NSEG-1];
      out_err   = out_valid & err_q;
      out_iters = out_valid ? iters_q : '0;
   end

`ifdef ETAII_CTRL_STATS_EN
   logic [31:0] ops_q, ops_d, errs_q, errs_d, its_q, its_d;
   logic [32:0] its_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ops_q  <= '0;
         errs_q <= '0;
         its_q  <= '0;
      end else begin
         ops_q  <= ops_d;
         errs_q <= errs_d;
         its_q  <= its_d;
      end
   end

   // Clear has priority over a coincident result handshake; all counters saturate
   always_comb begin
      ops_d   = ops_q;
      errs_d  = errs_q;
      its_d   = its_q;
      its_sum = {1'b0, its_q} + {{(33-ITW){1'b0}}, out_iters};
      if (stat_clr) begin
         ops_d  = '0;
         errs_d = '0;
         its_d  = '0;
      end else if (out_valid && out_ready) begin
         if (ops_q != '1) ops_d = ops_q + 32'd1;
         if (out_err && errs_q != '1) errs_d = errs_q + 32'd1;
         its_d = its_sum[32] ? '1 : its_sum[31:0];
      end
   end

   assign stat_ops   = ops_q;
   assign stat_errs  = errs_q;
   assign stat_iters = its_q;
`endif

endmodule
